dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences every data-memory transaction from the MEM stage and shares the single data-memory port with a secondary requester (boot loader / debug port, "aux").
- Owns the memory control pins (cs_d_n, rd, wr, d_addr, Data_write, byte_en).
- Handles wait states, byte-lane steering, load sign/zero extension and pipeline stall generation.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS without d_ack before abort; 0 disables the timeout.
- STARVE_LIMIT, 4: consecutive CPU grants while aux is pending, after which aux wins the next arbitration.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cpu_req  in  1  MEM-stage load/store valid; held until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data, right-aligned.
- cpu_whb  in  2  size: 00 byte, 01 half, 10 word; 11 is treated as word.
- cpu_su  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- cpu_rdata  out  32  extended load data; valid while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  with cpu_done: access aborted (timeout or misaligned).
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done.
- aux_req  in  1  aux request; held until aux_done. Word-only.
- aux_we  in  1  aux store.
- aux_addr  in  32  aux address; bits [1:0] ignored.
- aux_wdata  in  32  aux store data.
- aux_rdata  out  32  raw word read.
- aux_done  out  1  one-cycle completion pulse.
- aux_err  out  1  with aux_done: timeout.
- cs_d_n  out  1  chip select, active-low.
- rd  out  1  read strobe.
- wr  out  1  write strobe.
- d_addr  out  32  word-aligned address ({addr[31:2], 2'b00}).
- Data_write  out  32  lane-steered store data.
- byte_en  out  4  write byte enables.
- Data_read  in  32  memory read data.
- d_ack  in  1  memory ready; sampled in ACCESS.

Behaviour:
- States: IDLE, ACCESS, RESP.
  - IDLE: if any request is pending, latch the winner's fields into registers and go to ACCESS.
  - ACCESS: memory outputs are driven from the latched registers. On d_ack, capture Data_read and go to RESP. On timeout, set err and go to RESP.
  - RESP: pulse the owner's done (and err if set), drive rdata, then return to IDLE.
- Minimum latency: request seen in IDLE at cycle 0; done at cycle 2 if d_ack arrives in cycle 1. Each wait state adds one cycle. Back-to-back transactions cost 3 cycles each.
- All outputs are registered except cpu_stall.
- Reset values: cs_d_n=1; rd=wr=0; d_addr=Data_write=0; byte_en=0; all done/err=0; rdata=0; state IDLE; starvation counter 0.
- Asynchronous reset mid-transaction aborts immediately with no done pulse; requesters must re-issue.
- Outside ACCESS: cs_d_n=1, rd=wr=0, byte_en=0. The bus is never tri-stated.
- Memory strobes in ACCESS: rd=~we; wr=we; byte_en is nonzero only for stores.
- Arbitration:
  - CPU has priority.
  - The starvation counter increments on each CPU grant made while aux_req=1, and clears on any aux grant.
  - When the counter equals STARVE_LIMIT, aux wins.
  - On simultaneous requests with counter < STARVE_LIMIT, CPU wins.
  - A request is never preempted once latched.
- Store lane steering (o = addr[1:0]):
  - byte: data replicated to all four lanes; byte_en = 4'b0001<<o.
  - half: data replicated to both halves; byte_en = addr[1] ? 1100 : 0011.
  - word: byte_en = 1111.
- Load extraction:
  - byte = Data_read[8*o+:8]; half = Data_read[16*addr[1]+:16].
  - Extended per su; su is ignored for words.
- Misaligned accesses without the optional feature: low address bits are used as stated above. A half at o=3 uses the upper half; a word ignores [1:0].
- Timeout: counter resets on entering ACCESS. Abort occurs when count reaches TIMEOUT-1 without d_ack. The abort returns rdata=0 and does not perform the write.
- Requests dropped before done is pulsed are illegal; behaviour in that case is undefined.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined: a CPU half with addr[0]=1, or a word with addr[1:0]!=0, skips ACCESS entirely. The block goes IDLE→RESP, pulses cpu_done with cpu_err=1 and rdata=0, and memory sees no strobe.
- Undefined: no check; misaligned accesses follow the base rules.

Decomposition:
- Shared package / parameters.vh: size encodings (WHB_BYTE=2'b00, WHB_HALF=2'b01, WHB_WORD=2'b10), FSM state encodings, and existing `I2/`S opcodes for the MEM-stage request decode.
- One natural sub-module: dmem_lane_steer. It is purely combinational and takes addr[1:0], whb, su, wdata and Data_read, producing byte_en, steered write data and extended read data.

Test Plan:
- CPU lb, addr 0x103, su=1, memory returns 0x80FF_FF12, d_ack immediate → byte 0x80 is extended to cpu_rdata=0xFFFF_FF80; cpu_done at cycle 2; rd=1 for exactly one cycle; d_addr=0x100.
- CPU sh, addr 0x202, wdata 0x0000_BEEF, d_ack after 3 waits → Data_write=0xBEEF_BEEF, byte_en=1100, wr held 4 cycles, cpu_stall high until done.
- CPU and aux request continuously, STARVE_LIMIT=4 → grant order CPU,CPU,CPU,CPU,AUX,CPU…; no aux starvation.
- Load with d_ack never asserted, TIMEOUT=16 → abort after 16 ACCESS cycles; cpu_done=1, cpu_err=1, cpu_rdata=0; cs_d_n returns to 1.
- rst asserted during an ACCESS wait → cs_d_n=1 and strobes drop asynchronously; no done pulse; a fresh request after reset completes normally.
- With DMEM_MISALIGN_CHK_EN, lw at 0x101 → cpu_err=1 at cycle 1, cs_d_n stays 1; without the macro, the same access reads word 0x100.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared size/state encodings for the data-memory access controller
package dmem_access_ctrl_pkg;

    localparam logic [1:0] WHB_BYTE = 2'b00;
    localparam logic [1:0] WHB_HALF = 2'b01;
    localparam logic [1:0] WHB_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // A half must sit on an even address; a word (or size 11) on a word boundary.
    function automatic logic f_misaligned(input logic [1:0] addr_lo, input logic [1:0] whb);
        logic w_mis;
        case (whb)
            WHB_BYTE: w_mis = 1'b0;
            WHB_HALF: w_mis = addr_lo[0];
            default:  w_mis = (addr_lo != 2'b00);
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// rtl/dmem_lane_steer.sv - combinational store lane steering and load extraction/extension
module dmem_lane_steer
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_whb,
    input  logic        i_su,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_mem,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_half = i_addr_lo[1] ? i_rdata_mem[31:16] : i_rdata_mem[15:0];

    // Pick the addressed byte lane out of the memory word
    always_comb begin
        w_byte = i_rdata_mem[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata_mem[7:0];
            2'd1:    w_byte = i_rdata_mem[15:8];
            2'd2:    w_byte = i_rdata_mem[23:16];
            default: w_byte = i_rdata_mem[31:24];
        endcase
    end

    // Replicate store data across lanes, build enables, and extend loads; size 11 acts as word
    always_comb begin
        o_byte_en = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata_mem;
        case (i_whb)
            WHB_BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = {{24{i_su & w_byte[7]}}, w_byte};
            end
            WHB_HALF: begin
                o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_wdata[15:0]}};
                o_rdata   = {{16{i_su & w_half[15]}}, w_half};
            end
            default: begin
                o_byte_en = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - CPU/aux data-memory port sequencer; optional DMEM_MISALIGN_CHK_EN rejects misaligned CPU accesses
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_whb,
    input  logic        cpu_su,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic [31:0] aux_rdata,
    output logic        aux_done,
    output logic        aux_err,
    output logic        cs_d_n,
    output logic        rd,
    output logic        wr,
    output logic [31:0] d_addr,
    output logic [31:0] Data_write,
    output logic [3:0]  byte_en,
    input  logic [31:0] Data_read,
    input  logic        d_ack
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);

    state_t        r_state, w_next;
    logic [TW-1:0] r_tcnt;
    logic [SW-1:0] r_starve;
    logic          r_is_aux, r_we, r_su;
    logic [1:0]    r_addr_lo, r_whb;

    logic          w_aux_win, w_grant_cpu, w_grant_aux, w_finish, w_abort, w_skip;
    logic          w_tmo_hit, w_misalign, w_idle;
    logic          w_win_we, w_win_su;
    logic [1:0]    w_win_whb;
    logic [31:0]   w_win_addr, w_win_wdata;
    logic [1:0]    w_s_addr_lo, w_s_whb;
    logic          w_s_su;
    logic [3:0]    w_steer_be;
    logic [31:0]   w_steer_wdata, w_steer_rdata;

    // Aux takes the port when the CPU is absent or has been granted STARVE_LIMIT times in a row
    assign w_aux_win   = aux_req & (~cpu_req | (r_starve == SLIM));
    assign w_win_we    = w_aux_win ? aux_we    : cpu_we;
    assign w_win_addr  = w_aux_win ? aux_addr  : cpu_addr;
    assign w_win_wdata = w_aux_win ? aux_wdata : cpu_wdata;
    assign w_win_whb   = w_aux_win ? WHB_WORD  : cpu_whb;
    assign w_win_su    = w_aux_win ? 1'b0      : cpu_su;

    assign w_tmo_hit = (TIMEOUT != 0) && (r_tcnt == TLAST);
    assign cpu_stall = cpu_req & ~cpu_done;

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_misalign = f_misaligned(cpu_addr[1:0], cpu_whb);
`else
    assign w_misalign = 1'b0;
`endif

    // The steering block sees the incoming winner in IDLE (to register store pins) and the latched request afterwards
    assign w_idle      = (r_state == ST_IDLE);
    assign w_s_addr_lo = w_idle ? w_win_addr[1:0] : r_addr_lo;
    assign w_s_whb     = w_idle ? w_win_whb       : r_whb;
    assign w_s_su      = w_idle ? w_win_su        : r_su;

    dmem_lane_steer u_lane_steer (
        .i_addr_lo   (w_s_addr_lo),
        .i_whb       (w_s_whb),
        .i_su        (w_s_su),
        .i_wdata     (w_win_wdata),
        .i_rdata_mem (Data_read),
        .o_byte_en   (w_steer_be),
        .o_wdata     (w_steer_wdata),
        .o_rdata     (w_steer_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode and per-cycle grant/completion events
    always_comb begin
        w_next      = r_state;
        w_grant_cpu = 1'b0;
        w_grant_aux = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        w_skip      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_aux_win) begin
                    w_grant_aux = 1'b1;
                    w_next      = ST_ACCESS;
                end else if (cpu_req) begin
                    w_grant_cpu = 1'b1;
                    if (w_misalign) begin
                        w_skip = 1'b1;
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (d_ack) begin
                    w_finish = 1'b1;
                    w_next   = ST_RESP;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_next  = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Starvation counter: counts CPU wins over a waiting aux, cleared whenever aux is served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_grant_aux) begin
            r_starve <= '0;
        end else if (w_grant_cpu && aux_req) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Latch the granted request, register memory pins for ACCESS and the response for RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_aux   <= 1'b0;
            r_we       <= 1'b0;
            r_su       <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_whb      <= WHB_BYTE;
            r_tcnt     <= '0;
            cs_d_n     <= 1'b1;
            rd         <= 1'b0;
            wr         <= 1'b0;
            d_addr     <= '0;
            Data_write <= '0;
            byte_en    <= 4'b0000;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            aux_done   <= 1'b0;
            aux_err    <= 1'b0;
            aux_rdata  <= '0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            aux_done <= 1'b0;
            aux_err  <= 1'b0;
            if (w_grant_cpu || w_grant_aux) begin
                r_is_aux  <= w_grant_aux;
                r_we      <= w_win_we;
                r_su      <= w_win_su;
                r_addr_lo <= w_win_addr[1:0];
                r_whb     <= w_win_whb;
                r_tcnt    <= '0;
            end
            if ((w_grant_cpu || w_grant_aux) && !w_skip) begin
                cs_d_n     <= 1'b0;
                rd         <= ~w_win_we;
                wr         <= w_win_we;
                d_addr     <= {w_win_addr[31:2], 2'b00};
                Data_write <= w_steer_wdata;
                byte_en    <= w_win_we ? w_steer_be : 4'b0000;
            end
            if (r_state == ST_ACCESS && !w_finish && !w_abort) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_finish || w_abort) begin
                cs_d_n  <= 1'b1;
                rd      <= 1'b0;
                wr      <= 1'b0;
                byte_en <= 4'b0000;
                if (r_is_aux) begin
                    aux_done  <= 1'b1;
                    aux_err   <= w_abort;
                    aux_rdata <= w_finish ? Data_read : 32'h0;
                end else begin
                    cpu_done  <= 1'b1;
                    cpu_err   <= w_abort;
                    cpu_rdata <= (w_finish && !r_we) ? w_steer_rdata : 32'h0;
                end
            end
            if (w_skip) begin
                cpu_done  <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_su;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_whb;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic        aux_req, aux_we;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic        aux_done, aux_err;
    logic        cs_d_n, rd, wr;
    logic [31:0] d_addr, Data_write, Data_read;
    logic [3:0]  byte_en;
    logic        d_ack;

    int n_cmp;
    int n_fail;
    int ncomp;
    int cnt;
    logic [10:0] exp_aux;

    dmem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_whb    (cpu_whb),
        .cpu_su     (cpu_su),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_err    (cpu_err),
        .cpu_stall  (cpu_stall),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_rdata  (aux_rdata),
        .aux_done   (aux_done),
        .aux_err    (aux_err),
        .cs_d_n     (cs_d_n),
        .rd         (rd),
        .wr         (wr),
        .d_addr     (d_addr),
        .Data_write (Data_write),
        .byte_en    (byte_en),
        .Data_read  (Data_read),
        .d_ack      (d_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_su = 0; cpu_addr = 0; cpu_wdata = 0; cpu_whb = 2'b00;
        aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
        Data_read = 0; d_ack = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_d_n", cs_d_n, 1);
        chk("rst_rd", rd, 0);
        chk("rst_wr", wr, 0);
        chk("rst_d_addr", d_addr, 0);
        chk("rst_data_write", Data_write, 0);
        chk("rst_byte_en", byte_en, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_aux_done", aux_done, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        rst = 1'b1;
        step();

        // lb 0x103 sign-extended, immediate ack
        cpu_we = 0; cpu_addr = 32'h103; cpu_whb = 2'b00; cpu_su = 1;
        Data_read = 32'h80FF_FF12; cpu_req = 1;
        #1 chk("t1_stall_c0", cpu_stall, 1);
        step();
        chk("t1_cs_c1", cs_d_n, 0);
        chk("t1_rd_c1", rd, 1);
        chk("t1_wr_c1", wr, 0);
        chk("t1_d_addr", d_addr, 32'h100);
        chk("t1_byte_en_load", byte_en, 0);
        chk("t1_done_c1", cpu_done, 0);
        d_ack = 1;
        step();
        chk("t1_done_c2", cpu_done, 1);
        chk("t1_rdata", cpu_rdata, 32'hFFFF_FF80);
        chk("t1_err", cpu_err, 0);
        chk("t1_rd_c2", rd, 0);
        chk("t1_cs_c2", cs_d_n, 1);
        chk("t1_stall_c2", cpu_stall, 0);
        cpu_req = 0; d_ack = 0;
        step();
        chk("t1_done_c3", cpu_done, 0);

        // sh 0x202 with three wait states
        cpu_we = 1; cpu_addr = 32'h202; cpu_wdata = 32'h0000_BEEF; cpu_whb = 2'b01; cpu_req = 1;
        step();
        chk("t2_data_write", Data_write, 32'hBEEF_BEEF);
        chk("t2_byte_en", byte_en, 4'b1100);
        chk("t2_rd", rd, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_wr_held", wr, 1);
            chk("t2_stall_held", cpu_stall, 1);
            if (i == 3) d_ack = 1;
            step();
        end
        chk("t2_done", cpu_done, 1);
        chk("t2_err", cpu_err, 0);
        chk("t2_wr_after", wr, 0);
        chk("t2_byte_en_after", byte_en, 0);
        cpu_req = 0; d_ack = 0;
        step();

        // sb 0x001
        cpu_addr = 32'h001; cpu_whb = 2'b00; cpu_wdata = 32'h1234_56A5; cpu_req = 1;
        step();
        chk("t2b_data_write", Data_write, 32'hA5A5_A5A5);
        chk("t2b_byte_en", byte_en, 4'b0010);
        d_ack = 1;
        step();
        chk("t2b_done", cpu_done, 1);
        cpu_req = 0; d_ack = 0;
        step();

        // continuous CPU and aux requests: aux served after four CPU grants
        cpu_we = 0; cpu_addr = 32'h500; cpu_whb = 2'b10;
        aux_we = 0; aux_addr = 32'h603;
        Data_read = 32'hCAFE_F00D; d_ack = 1;
        cpu_req = 1; aux_req = 1;
        exp_aux = 11'b010_0001_0000;
        ncomp = 0;
        for (int cyc = 0; cyc < 100 && ncomp < 11; cyc++) begin
            step();
            if (cs_d_n == 1'b0 && aux_req && ncomp == 4) chk("t3_aux_d_addr", d_addr, 32'h600);
            if (cpu_done || aux_done) begin
                chk("t3_grant_is_aux", aux_done, exp_aux[ncomp]);
                if (aux_done) chk("t3_aux_rdata", aux_rdata, 32'hCAFE_F00D);
                if (ncomp == 9) aux_req = 0;
                if (ncomp == 10) cpu_req = 0;
                ncomp++;
            end
        end
        chk("t3_completions", ncomp, 11);
        cpu_req = 0; aux_req = 0;

        // load with no ack: abort after 16 ACCESS cycles
        step();
        d_ack = 0; Data_read = 32'hDEAD_BEEF;
        cpu_addr = 32'h300; cpu_whb = 2'b10; cpu_we = 0; cpu_req = 1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (cs_d_n == 1'b0 && cpu_done == 1'b0) cnt++;
        end
        chk("t4_access_cycles", cnt, 16);
        step();
        chk("t4_done", cpu_done, 1);
        chk("t4_err", cpu_err, 1);
        chk("t4_rdata", cpu_rdata, 0);
        chk("t4_cs", cs_d_n, 1);
        cpu_req = 0;
        step();

        // asynchronous reset in the middle of a stalled store
        cpu_we = 1; cpu_addr = 32'h400; cpu_wdata = 32'h1122_3344; cpu_whb = 2'b10; cpu_req = 1;
        step();
        chk("t5_wr", wr, 1);
        chk("t5_data_write", Data_write, 32'h1122_3344);
        chk("t5_byte_en", byte_en, 4'b1111);
        step();
        step();
        #2 rst = 0;
        #1;
        chk("t5_cs_async", cs_d_n, 1);
        chk("t5_wr_async", wr, 0);
        chk("t5_byte_en_async", byte_en, 0);
        cpu_req = 0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (cpu_done) cnt++;
        end
        chk("t5_no_done", cnt, 0);
        rst = 1;
        step();
        cpu_we = 0; cpu_addr = 32'h402; cpu_whb = 2'b01; cpu_su = 1;
        Data_read = 32'h8001_7FFF; cpu_req = 1;
        step();
        chk("t5_fresh_rd", rd, 1);
        chk("t5_fresh_d_addr", d_addr, 32'h400);
        d_ack = 1;
        step();
        chk("t5_fresh_done", cpu_done, 1);
        chk("t5_fresh_rdata", cpu_rdata, 32'hFFFF_8001);
        cpu_req = 0; d_ack = 0;
        step();

        // lw at a misaligned address 0x101
        cpu_we = 0; cpu_addr = 32'h101; cpu_whb = 2'b10; cpu_su = 0;
        Data_read = 32'h0A0B_0C0D; cpu_req = 1;
        step();
`ifdef DMEM_MISALIGN_CHK_EN
        chk("t6_done_c1", cpu_done, 1);
        chk("t6_err_c1", cpu_err, 1);
        chk("t6_rdata", cpu_rdata, 0);
        chk("t6_cs_c1", cs_d_n, 1);
        cpu_req = 0;
        step();
        chk("t6_cs_c2", cs_d_n, 1);
        chk("t6_rd_c2", rd, 0);
`else
        chk("t6_cs_c1", cs_d_n, 0);
        chk("t6_rd_c1", rd, 1);
        chk("t6_d_addr", d_addr, 32'h100);
        d_ack = 1;
        step();
        chk("t6_done_c2", cpu_done, 1);
        chk("t6_err_c2", cpu_err, 0);
        chk("t6_rdata", cpu_rdata, 32'h0A0B_0C0D);
        cpu_req = 0; d_ack = 0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
